pipe_drain: RTL and testbench

PIPE_DRAIN -- requirements
Module: pipe_drain

---
 rtl/pipe_drain_pkg.sv | 20 ++
 rtl/pipe_drain_fifo.sv | 77 +++++++
 rtl/pipe_drain.sv | 142 ++++++++++++++
 tb/tb_pipe_drain.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_drain_pkg.sv
// Shared types and constants for the pipe_drain result-drain block.
package pipe_drain_pkg;

  localparam int unsigned CYC_W  = 16;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned SEEN_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_e;

  // Saturating +1 for the run-cycle counter.
  function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + CYC_W'(1);
  endfunction

endpackage

// File: rtl/pipe_drain_fifo.sv
// Result buffer for pipe_drain: power-of-two FIFO with a registered head word.
module pipe_drain_fifo #(
  parameter int unsigned W          = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          do_push, do_pop;

  // The head register is loaded with whatever will sit at rd_ptr_d, bypassing
  // the array when this cycle's write lands exactly there.
  always_comb begin
    do_pop   = pop_i && !empty_q && !flush_i;
    do_push  = push_i && !flush_i && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push && (wr_ptr_q == rd_ptr_d)) rdata_d = wdata_i;
      else if (do_pop)                       rdata_d = mem_q[rd_ptr_d];
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign rdata_o = rdata_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/pipe_drain.sv
// Drains a pipeline's results into a buffer until a target value or a timeout.
// Define PIPE_DRAIN_STATS_EN to add drop_cnt / seen_cnt statistics outputs.
module pipe_drain
  import pipe_drain_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  input  logic [W-1:0]      expect_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              done,
  output logic              timeout,
`ifdef PIPE_DRAIN_STATS_EN
  output logic [CYC_W-1:0]  cycles,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [SEEN_W-1:0] seen_cnt
`else
  output logic [CYC_W-1:0]  cycles
`endif
);

  state_e           state_q, state_d;
  logic [W-1:0]     expect_q, expect_d;
  logic [CYC_W-1:0] cycles_q, cycles_d, cyc_inc;
  logic             done_q, done_d, tout_q, tout_d;
  logic             overflow_q, overflow_d;
  logic             push, match, pop, drop;
  logic             fifo_empty, fifo_full;

  // start wins over a same-cycle word; matching looks at in_data, not the FIFO.
  assign push  = (state_q == RUN) && in_valid && !start;
  assign match = push && (in_data == expect_q);
  assign pop   = !fifo_empty && out_ready;
  assign drop  = push && fifo_full && !pop;

  pipe_drain_fifo #(.W(W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (start),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (out_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    expect_d   = expect_q;
    cycles_d   = cycles_q;
    done_d     = done_q;
    tout_d     = tout_q;
    overflow_d = overflow_q | drop;
    cyc_inc    = cyc_sat_inc(cycles_q);
    if (start) begin
      state_d    = RUN;
      expect_d   = expect_val;
      cycles_d   = '0;
      done_d     = 1'b0;
      tout_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          cycles_d = cyc_inc;
          if (match) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (cyc_inc == CYC_W'(TIMEOUT)) begin
            state_d = TOUT;
            tout_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      expect_q   <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      expect_q   <= expect_d;
      cycles_q   <= cycles_d;
      done_q     <= done_d;
      tout_q     <= tout_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign done      = done_q;
  assign timeout   = tout_q;
  assign cycles    = cycles_q;

`ifdef PIPE_DRAIN_STATS_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [SEEN_W-1:0] seen_cnt_q, seen_cnt_d;

  // Saturating counters of accepted and dropped words since the last start.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    seen_cnt_d = seen_cnt_q;
    if (start) begin
      drop_cnt_d = '0;
      seen_cnt_d = '0;
    end else begin
      if (push && (seen_cnt_q != '1)) seen_cnt_d = seen_cnt_q + SEEN_W'(1);
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      seen_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      seen_cnt_q <= seen_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign seen_cnt = seen_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_drain.sv
// Self-checking bench for pipe_drain against a queue-based reference model.
module tb_pipe_drain;
  import pipe_drain_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 10;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic [W-1:0]  in_data, expect_val, out_data;
  logic          out_valid, done, timeout;
  logic [15:0]   cycles;
`ifdef PIPE_DRAIN_STATS_EN
  logic [7:0]    drop_cnt;
  logic [15:0]   seen_cnt;
`endif

  pipe_drain #(.W(W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .expect_val (expect_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .done       (done),
    .timeout    (timeout),
`ifdef PIPE_DRAIN_STATS_EN
    .cycles     (cycles),
    .drop_cnt   (drop_cnt),
    .seen_cnt   (seen_cnt)
`else
    .cycles     (cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit           m_run, m_done, m_tout, m_ovf;
  int           m_cyc, m_drop, m_seen;
  logic [W-1:0] m_exp;
  logic [W-1:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_tout = 0; m_ovf = 0;
    m_cyc = 0; m_drop = 0; m_seen = 0; m_exp = '0;
    m_q.delete();
  endfunction

  function automatic void model_step(bit st, bit iv, logic [W-1:0] id, logic [W-1:0] ev, bit ordy);
    if (st) begin
      model_reset();
      m_run = 1;
      m_exp = ev;
      return;
    end
    if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
    if (m_run) begin
      if (iv) begin
        if (m_seen < 65535) m_seen++;
        if (m_q.size() < DEPTH) m_q.push_back(id);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (m_cyc < 65535) m_cyc++;
      if (iv && id == m_exp) begin
        m_run = 0; m_done = 1;
      end else if (m_cyc == TMO) begin
        m_run = 0; m_tout = 1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk({tag, ".data"}, 32'(out_data), 32'(m_q[0]));
    chk({tag, ".done"},    32'(done),    32'(m_done));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_tout));
    chk({tag, ".cycles"},  32'(cycles),  32'(m_cyc));
    chk({tag, ".ovf"},     32'(dut.overflow_q), 32'(m_ovf));
`ifdef PIPE_DRAIN_STATS_EN
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    chk({tag, ".seen_cnt"}, 32'(seen_cnt), 32'(m_seen));
`endif
  endtask

  task automatic cyc(input bit st, input bit iv, input logic [W-1:0] id,
                     input logic [W-1:0] ev, input bit ordy, input string tag);
    start = st; in_valid = iv; in_data = id; expect_val = ev; out_ready = ordy;
    @(posedge clk);
    model_step(st, iv, id, ev, ordy);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    expect_val = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;

    // Match on the fifth word, pass-through drain
    cyc(1, 0, 8'h00, 8'd4, 1, "t1_start");
    for (int i = 0; i < 5; i++) cyc(0, 1, W'(i), 8'h00, 1, "t1_feed");
    chk("t1_done_const", 32'(done), 32'd1);
    chk("t1_cycles_const", 32'(cycles), 32'd5);
    repeat (3) cyc(0, 0, 8'h00, 8'h00, 1, "t1_drain");
    chk("t1_empty_const", 32'(out_valid), 32'd0);

    // Timeout with a never-matching stream
    cyc(1, 0, 8'h00, 8'd9, 0, "t2_start");
    repeat (12) cyc(0, 1, 8'h00, 8'h00, 1, "t2_feed");
    chk("t2_timeout_const", 32'(timeout), 32'd1);
    chk("t2_done_const", 32'(done), 32'd0);
    chk("t2_cycles_const", 32'(cycles), 32'd10);
    repeat (2) cyc(0, 0, 8'h00, 8'h00, 1, "t2_drain");

    // Overflow with a stalled consumer, then push+pop while full
    cyc(1, 0, 8'h00, 8'hEE, 0, "t3_start");
    for (int i = 1; i <= 6; i++) cyc(0, 1, W'(i), 8'h00, 0, "t3_fill");
    chk("t3_ovf_const", 32'(dut.overflow_q), 32'd1);
    chk("t3_count_const", 32'(dut.u_fifo.count_q), 32'd4);
    chk("t3_head_const", 32'(out_data), 32'd1);
`ifdef PIPE_DRAIN_STATS_EN
    chk("t3_drop_const", 32'(drop_cnt), 32'd2);
`endif
    cyc(0, 1, 8'd7, 8'h00, 1, "t4_pushpop");
    chk("t4_count_const", 32'(dut.u_fifo.count_q), 32'd4);
    chk("t4_head_const", 32'(out_data), 32'd2);
`ifdef PIPE_DRAIN_STATS_EN
    chk("t4_drop_const", 32'(drop_cnt), 32'd2);
`endif
    repeat (5) cyc(0, 0, 8'h00, 8'h00, 1, "t4_drain");

    // Asynchronous reset in the middle of a run
    cyc(1, 0, 8'h00, 8'hEE, 0, "t5_start");
    for (int i = 0; i < 3; i++) cyc(0, 1, W'(8'h10 + i), 8'h00, 0, "t5_fill");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_valid_async", 32'(out_valid), 32'd0);
    chk("t5_state_async", 32'(dut.state_q), 32'(IDLE));
    chk("t5_cycles_async", 32'(cycles), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 8'h05, 8'h00, 1, "t5_idle");

    // Match arriving on the same cycle the counter reaches TIMEOUT
    cyc(1, 0, 8'h00, 8'h55, 1, "t6_start");
    repeat (9) cyc(0, 1, 8'h00, 8'h00, 1, "t6_wait");
    cyc(0, 1, 8'h55, 8'h00, 1, "t6_match");
    chk("t6_done_const", 32'(done), 32'd1);
    chk("t6_timeout_const", 32'(timeout), 32'd0);
    chk("t6_cycles_const", 32'(cycles), 32'd10);
    repeat (2) cyc(0, 0, 8'h00, 8'h00, 1, "t6_drain");

    // Random traffic, including start colliding with in_valid
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
          W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
          $urandom_range(0, 1) == 1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
